// File: rtl/syn_tle_loader.sv
// Tile loader: assembles A/B/C operand tiles from a row-per-beat stream and
// presents them to the MAC engine over a wide valid/ready handshake.
//
// state  | meaning
// LOAD_A | accepting A rows 0..M-1
// LOAD_B | accepting B rows 0..K-1
// LOAD_C | accepting C rows 0..M-1 (only when C_LOAD != 0)
// ISSUE  | full tile held on A_o/B_o/C_o, valid_o high until ready_i
module syn_tle_loader #(
  parameter int M      = 8,
  parameter int N      = 4,
  parameter int K      = 16,
  parameter int P      = 8,
  parameter int C_LOAD = 1,
  localparam int BEAT_W =
    ((C_LOAD != 0) && (N*4*P > ((K*P > N*P) ? K*P : N*P))) ? N*4*P
                                                            : ((K*P > N*P) ? K*P : N*P)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [BEAT_W-1:0]                   data_i,
  input  logic                                data_valid_i,
  output logic                                data_ready_o,
  output logic signed [M-1:0][K-1:0][P-1:0]   A_o,
  output logic signed [K-1:0][N-1:0][P-1:0]   B_o,
  output logic signed [M-1:0][N-1:0][4*P-1:0] C_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                busy_o
);

  localparam int ROWS_MAX = (M > K) ? M : K;
  localparam int ROW_W    = (ROWS_MAX > 1) ? $clog2(ROWS_MAX) : 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_C, ISSUE} state_e;

  state_e                        state_q, state_d;
  logic [ROW_W-1:0]              row_q, row_d;
  logic [M-1:0][K-1:0][P-1:0]    a_q, a_d;
  logic [K-1:0][N-1:0][P-1:0]    b_q, b_d;
  logic [M-1:0][N-1:0][4*P-1:0]  c_q, c_d;
  logic                          accept;
  logic                          last_m;
  logic                          last_k;

  assign data_ready_o = (state_q != ISSUE) && !rst_i;
  assign accept       = data_valid_i && data_ready_o;
  assign last_m       = (row_q == ROW_W'(M-1));
  assign last_k       = (row_q == ROW_W'(K-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD_A;
      row_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          for (int i = 0; i < M; i++) begin
            if (row_q == ROW_W'(i)) begin
              for (int j = 0; j < K; j++) a_d[i][j] = data_i[j*P +: P];
            end
          end
          if (last_m) begin
            row_d   = '0;
            state_d = LOAD_B;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          for (int i = 0; i < K; i++) begin
            if (row_q == ROW_W'(i)) begin
              for (int j = 0; j < N; j++) b_d[i][j] = data_i[j*P +: P];
            end
          end
          if (last_k) begin
            row_d   = '0;
            state_d = (C_LOAD != 0) ? LOAD_C : ISSUE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      LOAD_C: begin
        if (accept) begin
          if (last_m) begin
            row_d   = '0;
            state_d = ISSUE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      ISSUE: begin
        if (ready_i) begin
          row_d   = '0;
          state_d = LOAD_A;
        end
      end
      default: begin
        row_d   = '0;
        state_d = LOAD_A;
      end
    endcase
  end

  // C lanes are 4P wide and only exist on the stream when C is loaded
  if (C_LOAD != 0) begin : g_c_load
    always_comb begin
      c_d = c_q;
      if ((state_q == LOAD_C) && accept) begin
        for (int i = 0; i < M; i++) begin
          if (row_q == ROW_W'(i)) begin
            for (int j = 0; j < N; j++) c_d[i][j] = data_i[j*4*P +: 4*P];
          end
        end
      end
    end
  end else begin : g_c_zero
    assign c_d = '0;
  end

  assign A_o     = a_q;
  assign B_o     = b_q;
  assign C_o     = c_q;
  assign valid_o = (state_q == ISSUE);
  assign busy_o  = (state_q != LOAD_A) || (row_q != '0);

endmodule
